// File: rtl/alu_flag_unit.sv
// Registered ALU stage with a {Z,C,N,O} flag register behind the RF.
// Define ALU_SAT_EN to saturate ADD/ADDC/SUB results on signed overflow.
module alu_flag_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       FunSel,
  input  logic             in_valid,
  input  logic             flag_we,
  input  logic             flag_clr,
  output logic [WIDTH-1:0] OutALU,
  output logic             out_valid,
  output logic [3:0]       Flags
);

  typedef enum logic [3:0] {
    OP_PA   = 4'b0000,
    OP_PB   = 4'b0001,
    OP_NA   = 4'b0010,
    OP_NB   = 4'b0011,
    OP_ADD  = 4'b0100,
    OP_ADDC = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_AND  = 4'b0111,
    OP_OR   = 4'b1000,
    OP_XOR  = 4'b1001,
    OP_LSL  = 4'b1010,
    OP_LSR  = 4'b1011,
    OP_ASL  = 4'b1100,
    OP_ASR  = 4'b1101,
    OP_CSL  = 4'b1110,
    OP_CSR  = 4'b1111
  } op_e;

  localparam int MSB = WIDTH - 1;

  op_e              op;
  logic             cin;
  logic             is_add;
  logic             is_addc;
  logic             is_sub;
  logic             is_arith;
  logic [WIDTH-1:0] b_op;
  logic             add_cin;
  logic [WIDTH:0]   sum;
  logic             ovf;
  logic [WIDTH-1:0] res;
  logic             c_new;
  logic             c_upd;
  logic             o_new;
  logic             o_upd;
  logic             z_new;
  logic             n_new;

  assign op       = op_e'(FunSel);
  assign cin      = Flags[2];
  assign is_add   = (op == OP_ADD);
  assign is_addc  = (op == OP_ADDC);
  assign is_sub   = (op == OP_SUB);
  assign is_arith = is_add | is_addc | is_sub;

  // One shared WIDTH+1 adder; SUB feeds ~B with a forced carry-in.
  assign b_op    = is_sub ? ~B : B;
  assign add_cin = is_sub | (is_addc & cin);
  assign sum     = {1'b0, A} + {1'b0, b_op}
                 + {{WIDTH{1'b0}}, add_cin};
  assign ovf     = (A[MSB] == b_op[MSB])
                 & (sum[MSB] != A[MSB]);

  always_comb begin
    res   = '0;
    c_new = 1'b0;
    c_upd = 1'b0;
    o_new = 1'b0;
    o_upd = 1'b0;
    unique case (op)
      OP_PA: res = A;
      OP_PB: res = B;
      OP_NA: res = ~A;
      OP_NB: res = ~B;
      OP_ADD, OP_ADDC, OP_SUB: begin
        res   = sum[WIDTH-1:0];
        c_new = sum[WIDTH];
        c_upd = 1'b1;
        o_new = ovf;
        o_upd = 1'b1;
      end
      OP_AND: res = A & B;
      OP_OR:  res = A | B;
      OP_XOR: res = A ^ B;
      OP_LSL: begin
        res   = {A[MSB-1:0], 1'b0};
        c_new = A[MSB];
        c_upd = 1'b1;
      end
      OP_LSR: begin
        res   = {1'b0, A[MSB:1]};
        c_new = A[0];
        c_upd = 1'b1;
      end
      OP_ASL: begin
        res   = {A[MSB-1:0], 1'b0};
        c_new = A[MSB];
        c_upd = 1'b1;
        o_new = A[MSB] ^ A[MSB-1];
        o_upd = 1'b1;
      end
      OP_ASR: begin
        res   = {A[MSB], A[MSB:1]};
        c_new = A[0];
        c_upd = 1'b1;
      end
      OP_CSL: begin
        res   = {A[MSB-1:0], cin};
        c_new = A[MSB];
        c_upd = 1'b1;
      end
      OP_CSR: begin
        res   = {cin, A[MSB:1]};
        c_new = A[0];
        c_upd = 1'b1;
      end
    endcase
`ifdef ALU_SAT_EN
    // Overflow direction follows the common operand sign.
    if (is_arith && ovf) begin
      res = A[MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                   : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  assign z_new = (res == '0);
  assign n_new = res[MSB];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      OutALU    <= '0;
      out_valid <= 1'b0;
      Flags     <= 4'b0000;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        OutALU <= res;
      end
      if (flag_clr) begin
        Flags <= 4'b0000;
      end else if (in_valid && flag_we) begin
        Flags[3] <= z_new;
        Flags[1] <= n_new;
        if (c_upd) begin
          Flags[2] <= c_new;
        end
        if (o_upd) begin
          Flags[0] <= o_new;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_flag_unit.sv
// Directed bench for alu_flag_unit; flags read as {Z,C,N,O}.
module tb_alu_flag_unit;

  logic       clk;
  logic       rst;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] FunSel;
  logic       in_valid;
  logic       flag_we;
  logic       flag_clr;
  logic [7:0] OutALU;
  logic       out_valid;
  logic [3:0] Flags;

  int checks;
  int errors;

  alu_flag_unit #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .FunSel    (FunSel),
    .in_valid  (in_valid),
    .flag_we   (flag_we),
    .flag_clr  (flag_clr),
    .OutALU    (OutALU),
    .out_valid (out_valid),
    .Flags     (Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] f,
                      input logic [7:0] a,
                      input logic [7:0] b,
                      input logic v,
                      input logic we,
                      input logic clr);
    @(negedge clk);
    FunSel   = f;
    A        = a;
    B        = b;
    in_valid = v;
    flag_we  = we;
    flag_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic expect3(input string tag,
                         input logic [7:0] r,
                         input logic v,
                         input logic [3:0] fl);
    chk({tag, "_out"}, OutALU, r);
    chk({tag, "_vld"}, {7'd0, out_valid}, {7'd0, v});
    chk({tag, "_flg"}, {4'd0, Flags}, {4'd0, fl});
  endtask

  initial begin
    logic [7:0] ovf_res;
    logic [3:0] ovf_flg;
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    A        = 8'h00;
    B        = 8'h00;
    FunSel   = 4'h0;
    in_valid = 1'b0;
    flag_we  = 1'b0;
    flag_clr = 1'b0;
`ifdef ALU_SAT_EN
    ovf_res = 8'h7F;
    ovf_flg = 4'b0001;
`else
    ovf_res = 8'h80;
    ovf_flg = 4'b0011;
`endif

    @(posedge clk);
    #1;
    expect3("reset", 8'h00, 1'b0, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    step(4'b0100, 8'h7F, 8'h01, 1, 1, 0);
    expect3("add_ovf", ovf_res, 1'b1, ovf_flg);

    step(4'b0110, 8'h05, 8'h05, 1, 1, 0);
    expect3("sub_zero", 8'h00, 1'b1, 4'b1100);

    step(4'b0110, 8'h03, 8'h05, 1, 1, 0);
    expect3("sub_borrow", 8'hFE, 1'b1, 4'b0010);

    step(4'b0100, 8'hFF, 8'h01, 1, 1, 0);
    expect3("add_carry", 8'h00, 1'b1, 4'b1100);
    step(4'b0101, 8'h00, 8'h00, 1, 1, 0);
    expect3("addc", 8'h01, 1'b1, 4'b0000);

    step(4'b0100, 8'hFF, 8'h01, 1, 1, 0);
    expect3("set_c", 8'h00, 1'b1, 4'b1100);
    step(4'b1110, 8'h80, 8'h00, 1, 1, 0);
    expect3("csl", 8'h01, 1'b1, 4'b0100);
    step(4'b1111, 8'h02, 8'h00, 1, 1, 0);
    expect3("csr", 8'h81, 1'b1, 4'b0010);

    step(4'b0100, 8'h11, 8'h22, 0, 1, 0);
    expect3("idle", 8'h81, 1'b0, 4'b0010);

    step(4'b1001, 8'h33, 8'h33, 1, 0, 0);
    expect3("xor_nowe", 8'h00, 1'b1, 4'b0010);

    step(4'b0100, 8'h7F, 8'h01, 1, 1, 1);
    expect3("clr_pri", ovf_res, 1'b1, 4'b0000);

    step(4'b0000, 8'hA5, 8'h3C, 1, 0, 0);
    chk("pass_a", OutALU, 8'hA5);
    step(4'b0001, 8'hA5, 8'h3C, 1, 0, 0);
    chk("pass_b", OutALU, 8'h3C);
    step(4'b0010, 8'hA5, 8'h3C, 1, 0, 0);
    chk("not_a", OutALU, 8'h5A);
    step(4'b0011, 8'hA5, 8'h3C, 1, 0, 0);
    chk("not_b", OutALU, 8'hC3);
    step(4'b0111, 8'hA5, 8'h3C, 1, 0, 0);
    chk("and", OutALU, 8'h24);
    step(4'b1000, 8'hA5, 8'h3C, 1, 0, 0);
    chk("or", OutALU, 8'hBD);
    step(4'b1010, 8'hA5, 8'h00, 1, 1, 0);
    expect3("lsl", 8'h4A, 1'b1, 4'b0100);
    step(4'b1011, 8'hA4, 8'h00, 1, 1, 0);
    expect3("lsr", 8'h52, 1'b1, 4'b0000);

    step(4'b1100, 8'h40, 8'h00, 1, 1, 0);
    expect3("asl", 8'h80, 1'b1, 4'b0011);
    step(4'b1101, 8'h81, 8'h00, 1, 1, 0);
    expect3("asr", 8'hC0, 1'b1, 4'b0111);

    step(4'b0100, 8'h10, 8'h20, 1, 0, 0);
    expect3("pre_rst", 8'h30, 1'b1, 4'b0111);
    @(negedge clk);
    FunSel   = 4'b0100;
    A        = 8'h10;
    B        = 8'h20;
    in_valid = 1'b1;
    flag_we  = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    expect3("async_rst", 8'h00, 1'b0, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    step(4'b0100, 8'h01, 8'h01, 1, 1, 0);
    expect3("post_rst", 8'h02, 1'b1, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_flag_unit.md
Name: alu_flag_unit

Overview:
- Registered 8-bit ALU stage directly downstream of the register file.
- Operand A comes from the RF O1 port and operand B from the RF O2 port.
- Computes one of 16 functions, registers the result with a valid strobe, and maintains a 4-bit flag register (Z, C, N, O).
- The result feeds back to the RF load input `i` and onward to the memory/address stages.

Parameters:
- WIDTH, 8, operand/result width; flag bit positions below assume WIDTH-1 as MSB.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- A  input  WIDTH  operand A (RF O1)
- B  input  WIDTH  operand B (RF O2)
- FunSel  input  4  operation select
- in_valid  input  1  operands/FunSel valid this cycle
- flag_we  input  1  allow flag update for this operation
- flag_clr  input  1  synchronous clear of flag register
- OutALU  output  WIDTH  registered result
- out_valid  output  1  OutALU updated this cycle
- Flags  output  4  {Z,C,N,O} register

Behaviour:
- Reset (async, rst=1): OutALU=0, out_valid=0, Flags=0000. Reset asserted mid-operation discards the in-flight op; the first valid op after rst deasserts behaves as from cold start.
- Latency: 1 cycle. An op sampled at edge n with in_valid=1 gives OutALU/out_valid=1 after edge n. With in_valid=0, out_valid=0 next cycle and OutALU holds. Back-to-back valid ops are allowed every cycle; no backpressure.
- Function table (Cin = current Flags.C, the value registered before this edge):
  - 0000 A; 0001 B; 0010 ~A; 0011 ~B
  - 0100 A+B; 0101 A+B+Cin; 0110 A-B, computed as A+~B+1
  - 0111 A&B; 1000 A|B; 1001 A^B
  - 1010 LSL A; 1011 LSR A; 1100 ASL A = A<<1
  - 1101 ASR A = {A[7],A[7:1]}; 1110 CSL = {A[6:0],Cin}; 1111 CSR = {Cin,A[7:1]}
- Flag update occurs only when in_valid=1 and flag_we=1.
  - Z = (result==0) and N = result[7] are updated for all ops.
  - C is updated for ops 0100-0110 (carry out of bit 7; for SUB, C=1 means no borrow).
  - C is updated for 1010, 1100 and 1110 with A[7], and for 1011, 1101 and 1111 with A[0].
  - O is updated for ADD/ADDC/SUB using signed overflow of the two operands as presented to the adder, and for ASL as A[7]^A[6].
  - All flags not listed for an op hold their value.
- flag_clr=1 forces Flags=0000 at the edge and has priority over flag_we; OutALU/out_valid are unaffected.
- Carry chaining: an ADDC/CSL/CSR op at edge n sees C written by the op at edge n-1. There is no combinational bypass.
- Width rule: all arithmetic is WIDTH+1 internally; the result is truncated to WIDTH.

Optional Feature:
- Macro: ALU_SAT_EN.
- Defined: for ADD/ADDC/SUB, when signed overflow occurs, OutALU saturates to 0x7F (positive overflow) or 0x80 (negative overflow). Z/N are computed on the saturated value; O and C are computed from the unsaturated sum.
- Undefined: OutALU wraps (truncated sum). All other behaviour is identical.

Test Plan:
- Reset mid-stream: run ADD with A=0x10, B=0x20, then assert rst between edges → OutALU=0x00, out_valid=0, Flags=0000 immediately, without waiting for a clock edge.
- Overflow (flag_we=1): FunSel=0100, A=0x7F, B=0x01 → OutALU=0x80 (0x7F with ALU_SAT_EN), Z0 C0 N1 O1.
- Subtract to zero: FunSel=0110, A=0x05, B=0x05 → OutALU=0x00, Z1 C1 N0 O0.
- Carry chain: FunSel=0100, A=0xFF, B=0x01 → OutALU=0x00, C=1; next cycle FunSel=0101, A=0x00, B=0x00 → OutALU=0x01, C=0.
- Rotate through carry: with C=1, FunSel=1110, A=0x80 → OutALU=0x01, C=1; next FunSel=1111, A=0x02 → OutALU=0x81, C=0.
- Gating: in_valid=0 → out_valid=0, OutALU holds; in_valid=1, flag_we=0, A^B=0x00 → Flags unchanged; flag_clr=1 together with flag_we=1 → Flags=0000.
